// File: rtl/sram_pkg.sv
// Widths and FSM encoding shared by the SRAM request arbiter and the SRAM controller.
// Also defines the packed {addr, data} entry held by the write FIFO.
package sram_pkg;

    localparam int RAM_AW = 20;
    localparam int RAM_DW = 32;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ISSUE   = 3'd1,
        ST_WAIT_LO = 3'd2,
        ST_WAIT_HI = 3'd3,
        ST_DONE    = 3'd4
    } arb_state_e;

    typedef struct packed {
        logic [RAM_AW-1:0] addr;
        logic [RAM_DW-1:0] data;
    } wr_entry_t;

endpackage

// File: rtl/sram_wr_fifo.sv
// Synchronous 2^AW-deep FIFO with wrapping pointers; head is visible combinationally, pop takes effect on the edge.
// Latency: a push is visible on the next edge. Backpressure: full_o; a push while full is taken only alongside a pop.
module sram_wr_fifo #(
    parameter int AW = 3,
    parameter int DW = 52
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    input  logic [DW-1:0] push_dat_i,
    input  logic          pop_i,
    output logic [DW-1:0] head_dat_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [AW:0]   count_o
);

    localparam int DEPTH = 1 << AW;

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wptr_q;
    logic [AW-1:0] rptr_q;
    logic [AW:0]   count_q;
    logic          do_push;
    logic          do_pop;

    assign full_o     = (count_q == (AW+1)'(DEPTH));
    assign empty_o    = (count_q == '0);
    assign count_o    = count_q;
    assign head_dat_o = mem_q[rptr_q];
    assign do_pop     = pop_i & ~empty_o;
    assign do_push    = push_i & (~full_o | do_pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop)  rptr_q <= rptr_q + 1'b1;
            count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    // Storage needs no reset: entries are only read once count covers them.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= push_dat_i;
    end

endmodule

// File: rtl/sram_req_arb.sv
// Write FIFO plus one read slot arbitrated onto level-held ram_read/ram_write; 2 cycles overhead plus controller time per command.
// Backpressure via wr_ready (FIFO full) and rd_ready (read busy); SRAM_ARB_TIMEOUT_EN adds a wait-phase watchdog and sticky err.
module sram_req_arb
    import sram_pkg::*;
#(
    parameter int FIFO_AW = 3,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [RAM_AW-1:0] wr_addr,
    input  logic [RAM_DW-1:0] wr_data,
    input  logic              rd_req,
    output logic              rd_ready,
    input  logic [RAM_AW-1:0] rd_addr,
    output logic              rd_valid,
    output logic [RAM_DW-1:0] rd_data,
    output logic              ram_read,
    output logic              ram_write,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [RAM_DW-1:0] ram_wdata,
    input  logic              ram_done,
    input  logic [RAM_DW-1:0] ram_rdata,
    output logic [FIFO_AW:0]  fifo_count,
    output logic              err
);

    arb_state_e        state_q;
    arb_state_e        state_d;
    wr_entry_t         push_ent;
    wr_entry_t         head_ent;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_pop;
    logic              strobe;
    logic              sel_rd;
    logic              start;
    logic              cmd_ok;
    logic              abort;
    logic              is_rd_q;
    logic              rd_pend_q;
    logic [RAM_AW-1:0] rd_addr_q;
    logic [RAM_AW-1:0] ram_addr_q;
    logic [RAM_DW-1:0] ram_wdata_q;
    logic              rd_valid_q;
    logic [RAM_DW-1:0] rd_data_q;

    assign push_ent.addr = wr_addr;
    assign push_ent.data = wr_data;

    sram_wr_fifo #(
        .AW (FIFO_AW),
        .DW ($bits(wr_entry_t))
    ) u_wr_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_i     (wr_valid & wr_ready),
        .push_dat_i (push_ent),
        .pop_i      (fifo_pop),
        .head_dat_o (head_ent),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .count_o    (fifo_count)
    );

    // A full FIFO takes priority over a pending read so the recorder never stalls.
    assign sel_rd = rd_pend_q & ~fifo_full;
    assign start  = (state_q == ST_IDLE) & (sel_rd | ~fifo_empty);
    assign cmd_ok = (state_q == ST_WAIT_HI) & ram_done;

`ifdef SRAM_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);

    logic          in_wait;
    logic [TW-1:0] wait_cnt_q;
    logic          err_q;

    assign in_wait = (state_q == ST_WAIT_LO) || (state_q == ST_WAIT_HI);
    assign abort   = in_wait & (wait_cnt_q == TW'(TIMEOUT - 1)) & ~cmd_ok;
    assign err     = err_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            wait_cnt_q <= in_wait ? wait_cnt_q + 1'b1 : '0;
            err_q      <= err_q | abort;
        end
    end
`else
    assign abort = 1'b0;
    assign err   = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= ST_IDLE;
        else      state_q <= state_d;
    end

    // WAIT_LO absorbs whatever ram_done looked like before the controller picked up the strobe.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (start) state_d = ST_ISSUE;
            ST_ISSUE:   state_d = ST_WAIT_LO;
            ST_WAIT_LO: begin
                if (abort)          state_d = ST_DONE;
                else if (!ram_done) state_d = ST_WAIT_HI;
            end
            ST_WAIT_HI: if (ram_done || abort) state_d = ST_DONE;
            ST_DONE:    state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        strobe   = 1'b0;
        fifo_pop = 1'b0;
        case (state_q)
            ST_ISSUE, ST_WAIT_LO, ST_WAIT_HI: strobe = 1'b1;
            ST_DONE:  fifo_pop = ~is_rd_q;
            default:  ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            is_rd_q     <= 1'b0;
            rd_pend_q   <= 1'b0;
            rd_addr_q   <= '0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= '0;
        end else begin
            if (start) begin
                is_rd_q    <= sel_rd;
                ram_addr_q <= sel_rd ? rd_addr_q : head_ent.addr;
                if (!sel_rd) ram_wdata_q <= head_ent.data;
            end
            if (is_rd_q && cmd_ok)     rd_data_q <= ram_rdata;
            else if (is_rd_q && abort) rd_data_q <= '0;
            rd_valid_q <= (state_q == ST_DONE) && is_rd_q;
            if ((state_q == ST_DONE) && is_rd_q) begin
                rd_pend_q <= 1'b0;
            end else if (rd_req && !rd_pend_q) begin
                rd_pend_q <= 1'b1;
                rd_addr_q <= rd_addr;
            end
        end
    end

    assign wr_ready  = ~fifo_full;
    assign rd_ready  = ~rd_pend_q;
    assign ram_read  = strobe & is_rd_q;
    assign ram_write = strobe & ~is_rd_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;
    assign rd_valid  = rd_valid_q;
    assign rd_data   = rd_data_q;

endmodule

// File: tb/tb_sram_req_arb.sv
// Directed bench for sram_req_arb: a transaction table plus hand sequences for full FIFO, wrap, reset and timeout.
// A behavioural controller model logs every command it completes, in order.
module tb_sram_req_arb;
    import sram_pkg::*;

    logic              clk = 1'b0;
    logic              rst;
    logic              wr_valid;
    logic              wr_ready;
    logic [RAM_AW-1:0] wr_addr;
    logic [RAM_DW-1:0] wr_data;
    logic              rd_req;
    logic              rd_ready;
    logic [RAM_AW-1:0] rd_addr;
    logic              rd_valid;
    logic [RAM_DW-1:0] rd_data;
    logic              ram_read;
    logic              ram_write;
    logic [RAM_AW-1:0] ram_addr;
    logic [RAM_DW-1:0] ram_wdata;
    logic              ram_done;
    logic [RAM_DW-1:0] ram_rdata;
    logic [3:0]        fifo_count;
    logic              err;

    always #5 clk = ~clk;

    sram_req_arb #(
        .FIFO_AW (3),
        .TIMEOUT (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .rd_req     (rd_req),
        .rd_ready   (rd_ready),
        .rd_addr    (rd_addr),
        .rd_valid   (rd_valid),
        .rd_data    (rd_data),
        .ram_read   (ram_read),
        .ram_write  (ram_write),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .ram_done   (ram_done),
        .ram_rdata  (ram_rdata),
        .fifo_count (fifo_count),
        .err        (err)
    );

    typedef struct {
        bit          is_rd;
        logic [19:0] addr;
        logic [31:0] data;
    } op_t;

    typedef struct {
        bit          is_rd;
        logic [19:0] addr;
        logic [31:0] data;
        int          lat;
    } vec_t;

    op_t         oplog[$];
    logic [31:0] mem [256];
    int          model_lat;
    bit          hold;
    bit          hang;
    int          checks;
    int          failures;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Controller model: drops ram_done while busy (at least two sampled edges), raises it when done.
    initial begin : ctrl_model
        int  mstate;
        int  mcnt;
        op_t cur;
        mstate    = 0;
        mcnt      = 0;
        ram_done  = 1'b1;
        ram_rdata = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                mstate   = 0;
                ram_done = 1'b1;
            end else begin
                case (mstate)
                    0: begin
                        if ((ram_read || ram_write) && hang) begin
                            ram_done = 1'b0;
                            mstate   = 3;
                        end else if ((ram_read || ram_write) && !hold) begin
                            cur.is_rd = ram_read;
                            cur.addr  = ram_addr;
                            cur.data  = ram_wdata;
                            ram_done  = 1'b0;
                            mcnt      = model_lat + 1;
                            mstate    = 1;
                        end
                    end
                    1: begin
                        if (mcnt == 0) begin
                            if (cur.is_rd) begin
                                cur.data  = mem[cur.addr[7:0]];
                                ram_rdata = cur.data;
                            end else begin
                                mem[cur.addr[7:0]] = cur.data;
                            end
                            oplog.push_back(cur);
                            ram_done = 1'b1;
                            mstate   = 2;
                        end else begin
                            mcnt--;
                        end
                    end
                    default: if (!ram_read && !ram_write) mstate = 0;
                endcase
            end
        end
    end

    task automatic do_write(input logic [19:0] a, input logic [31:0] d);
        int n;
        int base;
        base = oplog.size();
        @(negedge clk);
        wr_valid = 1'b1; wr_addr = a; wr_data = d;
        @(negedge clk);
        wr_valid = 1'b0;
        check("wr_count_after_push", 32'(fifo_count), 32'd1);
        check("wr_strobe_before_issue", 32'(ram_write), 32'd0);
        @(negedge clk);
        check("wr_strobe_issue", 32'(ram_write), 32'd1);
        check("wr_issue_addr", 32'(ram_addr), 32'(a));
        check("wr_issue_data", ram_wdata, d);
        n = 0;
        while (fifo_count != 0 && n < 200) begin @(negedge clk); n++; end
        check("wr_drain_in_time", 32'(n < 200), 32'd1);
        check("wr_strobe_released", 32'(ram_write), 32'd0);
        check("wr_one_command", 32'(oplog.size() - base), 32'd1);
        if (oplog.size() > base) begin
            check("wr_ctrl_addr", 32'(oplog[base].addr), 32'(a));
            check("wr_ctrl_data", oplog[base].data, d);
            check("wr_ctrl_is_write", 32'(oplog[base].is_rd), 32'd0);
        end
    endtask

    task automatic do_read(input logic [19:0] a, input logic [31:0] exp);
        int n;
        int base;
        base = oplog.size();
        @(negedge clk);
        rd_req = 1'b1; rd_addr = a;
        @(negedge clk);
        rd_req = 1'b0; rd_addr = 20'hFFFFF;
        check("rd_ready_busy", 32'(rd_ready), 32'd0);
        @(negedge clk);
        check("rd_strobe_issue", 32'(ram_read), 32'd1);
        check("rd_issue_addr", 32'(ram_addr), 32'(a));
        rd_req = 1'b1; rd_addr = 20'h3FFFF;
        @(negedge clk);
        rd_req = 1'b0;
        n = 0;
        while (rd_valid !== 1'b1 && n < 200) begin @(negedge clk); n++; end
        check("rd_valid_in_time", 32'(n < 200), 32'd1);
        check("rd_data", rd_data, exp);
        check("rd_ready_with_valid", 32'(rd_ready), 32'd1);
        check("rd_strobe_released", 32'(ram_read), 32'd0);
        @(negedge clk);
        check("rd_valid_one_cycle", 32'(rd_valid), 32'd0);
        check("rd_data_hold", rd_data, exp);
        @(negedge clk);
        check("rd_busy_req_ignored", 32'(ram_read), 32'd0);
        check("rd_one_command", 32'(oplog.size() - base), 32'd1);
        if (oplog.size() > base) begin
            check("rd_ctrl_addr", 32'(oplog[base].addr), 32'(a));
            check("rd_ctrl_is_read", 32'(oplog[base].is_rd), 32'd1);
        end
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end

    initial begin : main
        vec_t        vecs[7];
        int          n;
        int          i;
        int          base;
        int          high;
        logic [19:0] ea;
        checks   = 0;
        failures = 0;
        hold     = 1'b0;
        hang     = 1'b0;
        model_lat = 1;
        for (int k = 0; k < 256; k++) mem[k] = '0;
        rst = 1'b1; wr_valid = 1'b0; wr_addr = '0; wr_data = '0; rd_req = 1'b0; rd_addr = '0;
        #3 rst = 1'b0;
        repeat (3) @(negedge clk);

        check("rst_ram_read", 32'(ram_read), 32'd0);
        check("rst_ram_write", 32'(ram_write), 32'd0);
        check("rst_ram_addr", 32'(ram_addr), 32'd0);
        check("rst_ram_wdata", ram_wdata, 32'd0);
        check("rst_rd_valid", 32'(rd_valid), 32'd0);
        check("rst_rd_data", rd_data, 32'd0);
        check("rst_wr_ready", 32'(wr_ready), 32'd1);
        check("rst_rd_ready", 32'(rd_ready), 32'd1);
        check("rst_fifo_count", 32'(fifo_count), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        vecs[0] = '{1'b0, 20'h00010, 32'hDEADBEEF, 2};
        vecs[1] = '{1'b1, 20'h00010, 32'hDEADBEEF, 3};
        vecs[2] = '{1'b0, 20'h00020, 32'h12345678, 0};
        vecs[3] = '{1'b1, 20'h00099, 32'h00000000, 1};
        vecs[4] = '{1'b0, 20'h000FF, 32'hA5A5A5A5, 5};
        vecs[5] = '{1'b1, 20'h00020, 32'h12345678, 1};
        vecs[6] = '{1'b1, 20'h000FF, 32'hA5A5A5A5, 0};
        for (int v = 0; v < 7; v++) begin
            model_lat = vecs[v].lat;
            if (vecs[v].is_rd) do_read(vecs[v].addr, vecs[v].data);
            else               do_write(vecs[v].addr, vecs[v].data);
        end

        // Full FIFO with a pending read: the in-flight head write finishes, then the read, then the rest.
        model_lat = 1;
        hold = 1'b1;
        base = oplog.size();
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            wr_valid = 1'b1; wr_addr = 20'h100 + 20'(k); wr_data = 32'h5000 + 32'(k);
        end
        @(negedge clk);
        wr_valid = 1'b0;
        check("full_count", 32'(fifo_count), 32'd8);
        check("full_wr_ready", 32'(wr_ready), 32'd0);
        check("full_head_in_flight", 32'(ram_write), 32'd1);
        rd_req = 1'b1; rd_addr = 20'h00020;
        @(negedge clk);
        rd_req = 1'b0;
        wr_valid = 1'b1; wr_addr = 20'h001FF; wr_data = 32'hBAD0BAD0;
        @(negedge clk);
        wr_valid = 1'b0;
        check("full_rd_pending", 32'(rd_ready), 32'd0);
        check("full_push_refused", 32'(fifo_count), 32'd8);
        hold = 1'b0;
        n = 0;
        while (rd_valid !== 1'b1 && n < 300) begin @(negedge clk); n++; end
        check("full_rd_valid_in_time", 32'(n < 300), 32'd1);
        check("full_rd_data", rd_data, 32'h12345678);
        n = 0;
        while ((fifo_count != 0 || ram_write) && n < 300) begin @(negedge clk); n++; end
        repeat (3) @(negedge clk);
        check("full_op_total", 32'(oplog.size() - base), 32'd9);
        for (int k = 0; k < 9; k++) begin
            ea = (k == 0) ? 20'h100 : (k == 1) ? 20'h020 : 20'h100 + 20'(k - 1);
            if (oplog.size() > base + k) begin
                check("full_order_addr", 32'(oplog[base+k].addr), 32'(ea));
                check("full_order_is_rd", 32'(oplog[base+k].is_rd), 32'(k == 1));
            end
        end

        // Twenty writes through the 8-deep FIFO: pointers wrap twice.
        model_lat = 0;
        base = oplog.size();
        i = 0;
        n = 0;
        while (i < 20 && n < 2000) begin
            @(negedge clk);
            n++;
            wr_valid = 1'b1; wr_addr = 20'(i); wr_data = 32'(i * 3);
            if (wr_ready) i++;
        end
        @(negedge clk);
        wr_valid = 1'b0;
        check("wrap_all_accepted", 32'(i), 32'd20);
        n = 0;
        while ((fifo_count != 0 || ram_write) && n < 2000) begin @(negedge clk); n++; end
        repeat (3) @(negedge clk);
        check("wrap_op_total", 32'(oplog.size() - base), 32'd20);
        for (int k = 0; k < 20; k++) begin
            if (oplog.size() > base + k) begin
                check("wrap_addr", 32'(oplog[base+k].addr), 32'(k));
                check("wrap_data", oplog[base+k].data, 32'(k * 3));
            end
        end

        // Reset while a write sits in WAIT_HI, with a second write queued and a read pending.
        model_lat = 10;
        @(negedge clk);
        wr_valid = 1'b1; wr_addr = 20'h300; wr_data = 32'h1;
        @(negedge clk);
        wr_addr = 20'h301; wr_data = 32'h2;
        @(negedge clk);
        wr_valid = 1'b0;
        n = 0;
        while (!(ram_write && !ram_done) && n < 100) begin @(negedge clk); n++; end
        repeat (2) @(negedge clk);
        rd_req = 1'b1; rd_addr = 20'h00040;
        @(negedge clk);
        rd_req = 1'b0;
        check("midrst_pre_strobe", 32'(ram_write), 32'd1);
        check("midrst_pre_count", 32'(fifo_count), 32'd2);
        check("midrst_pre_rd_ready", 32'(rd_ready), 32'd0);
        base = oplog.size();
        rst = 1'b0;
        #1;
        check("midrst_ram_write", 32'(ram_write), 32'd0);
        check("midrst_ram_read", 32'(ram_read), 32'd0);
        check("midrst_fifo_count", 32'(fifo_count), 32'd0);
        check("midrst_rd_ready", 32'(rd_ready), 32'd1);
        check("midrst_wr_ready", 32'(wr_ready), 32'd1);
        check("midrst_rd_data", rd_data, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        check("midrst_stays_idle", 32'(ram_write | ram_read), 32'd0);
        check("midrst_no_command", 32'(oplog.size() - base), 32'd0);
        model_lat = 1;
        do_write(20'h00500, 32'hCAFEF00D);
        do_read(20'h00020, 32'h12345678);

`ifdef SRAM_ARB_TIMEOUT_EN
        // Controller never completes: each command is abandoned after 16 wait cycles.
        hang = 1'b1;
        base = oplog.size();
        @(negedge clk);
        wr_valid = 1'b1; wr_addr = 20'h00400; wr_data = 32'h77;
        @(negedge clk);
        wr_valid = 1'b0;
        n = 0;
        high = 0;
        while (err !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
            if (ram_write) high++;
        end
        check("tmo_err_set", 32'(err), 32'd1);
        check("tmo_strobe_cycles", 32'(high), 32'd17);
        check("tmo_strobe_low", 32'(ram_write), 32'd0);
        n = 0;
        while (fifo_count != 0 && n < 50) begin @(negedge clk); n++; end
        check("tmo_write_discarded", 32'(fifo_count), 32'd0);
        check("tmo_no_completion", 32'(oplog.size() - base), 32'd0);
        @(negedge clk);
        rd_req = 1'b1; rd_addr = 20'h00020;
        @(negedge clk);
        rd_req = 1'b0;
        n = 0;
        while (rd_valid !== 1'b1 && n < 200) begin @(negedge clk); n++; end
        check("tmo_rd_valid_in_time", 32'(n < 200), 32'd1);
        check("tmo_rd_data_zero", rd_data, 32'd0);
        check("tmo_rd_ready", 32'(rd_ready), 32'd1);
        check("tmo_err_sticky", 32'(err), 32'd1);
        hang = 1'b0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sram_req_arb.md
# sram_req_arb

Request arbiter and write buffer sitting directly upstream of the SRAM controller (`ram_ctrl`). Accepts buffered write requests from the recorder path and single outstanding read requests from the playback path, and issues one level-held `read`/`write` command at a time to the controller. Completes each command on the rising edge of the controller's `workdone`. Returns read data with a one-cycle valid pulse.

## Interface
- `FIFO_AW`, default 3: log2 of write FIFO depth (depth 8).
- `TIMEOUT`, default 64: cycle limit for a command's wait phases. Used only with `SRAM_ARB_TIMEOUT_EN`.
- `clk  in  1`: system clock; all logic on rising edge.
- `rst  in  1`: asynchronous, active-low reset.
- `wr_valid  in  1`: write request present.
- `wr_ready  out  1`: FIFO not full; a write is accepted when `wr_valid & wr_ready`.
- `wr_addr  in  20`: write address.
- `wr_data  in  32`: write data.
- `rd_req  in  1`: read request; accepted when `rd_ready`.
- `rd_ready  out  1`: no read pending or in flight.
- `rd_addr  in  20`: read address, captured on accept.
- `rd_valid  out  1`: one-cycle pulse, `rd_data` valid.
- `rd_data  out  32`: registered read data; holds until the next `rd_valid`.
- `ram_read  out  1`: controller read strobe (level).
- `ram_write  out  1`: controller write strobe (level).
- `ram_addr  out  20`: controller address.
- `ram_wdata  out  32`: controller write data.
- `ram_done  in  1`: controller `workdone`.
- `ram_rdata  in  32`: controller `out_data`.
- `fifo_count  out  FIFO_AW+1`: write FIFO occupancy.
- `err  out  1`: sticky timeout flag; tied 0 without the macro.

## Operation
- **Write FIFO:** `2^FIFO_AW` entries of {addr, data}, with wrap-around read/write pointers. A push and a pop in the same cycle leave the count unchanged. A push is allowed when full only if a pop happens in the same cycle; `wr_ready` is still 0 when full, so this case is never offered.
- **Read slot:** one register holding {pending flag, addr}. `rd_ready` = !pending.
- **FSM states:**
  - IDLE: selects the next command.
    - Read pending and FIFO not full: read.
    - Otherwise, FIFO not empty: write (FIFO head).
    - Else stays in IDLE.
    - When FIFO is full, writes win to avoid recorder stall.
  - ISSUE: drives address, data and strobe, then goes to WAIT_LO.
  - WAIT_LO: waits for `ram_done`=0 (the controller has started), then goes to WAIT_HI.
  - WAIT_HI: on `ram_done`=1, goes to DONE.
  - DONE: pops the FIFO (write) or clears the pending flag and pulses `rd_valid` (read), then returns to IDLE.
- The strobe stays asserted from ISSUE through WAIT_HI. It is cleared on the same edge that enters DONE, so the controller's idle state sees it low.
- `ram_addr`/`ram_wdata` are registered in ISSUE and held until the next ISSUE.
- `ram_done`'s value after reset may be undefined; the WAIT_LO phase makes this irrelevant.
- `rd_data` is loaded from `ram_rdata` on entry to DONE.
- Reset values: `ram_read`=0, `ram_write`=0, `ram_addr`=0, `ram_wdata`=0, `rd_valid`=0, `rd_data`=0, `wr_ready`=1, `rd_ready`=1, `fifo_count`=0, `err`=0, FSM in IDLE.
- Reset mid-command aborts at once: FIFO and read slot are cleared, strobes drop.
- Read-after-write address hazards are not checked. Ordering across ports is the caller's responsibility.

## Timing
- Accept to FIFO/slot: visible on the next edge. Earliest ISSUE follows one cycle later.
- Command latency: 2 cycles of overhead (IDLE→ISSUE, DONE) plus the controller's own cycles. Back-to-back commands are separated by at least one IDLE cycle.
- `rd_valid` is high for exactly one cycle, in the cycle after DONE registers. `rd_ready` rises in that same cycle.
- A `rd_req` arriving while `rd_ready`=0 is ignored, not queued.

## Configuration
- `SRAM_ARB_TIMEOUT_EN` defined:
  - A counter runs during WAIT_LO/WAIT_HI.
  - When it reaches `TIMEOUT`, the FSM goes to DONE, strobes drop and `err` sets (sticky until reset).
  - A timed-out write is popped and discarded. A timed-out read returns `rd_data`=0 with `rd_valid`.
- Undefined: no counter, waits indefinitely, `err`=0.

## Structure
- Package `sram_pkg` holds the FSM state enum, `RAM_AW`=20 and `RAM_DW`=32, which are shared with the controller.
- Sub-module `sram_wr_fifo` is a parameterised synchronous FIFO with full/empty/count outputs.

## Test plan
- **Single write:** push addr 0x00010, data 0xDEADBEEF. Expect one `ram_write` assertion with those values, dropped after `ram_done` rises; `fifo_count` goes 1→0.
- **Read:** issue `rd_req` at addr 0x00010 with the controller model returning 0xDEADBEEF. Expect one `rd_valid` pulse with `rd_data`=0xDEADBEEF and `rd_ready` back to 1.
- **Full FIFO plus read:** push 8 writes, then `rd_req`. Expect `wr_ready`=0, and the write at the FIFO head issued before the read. Once the count is 7, the read goes next.
- **Wrap-around:** issue 20 sequential writes (addr i, data i*3). Expect the controller to see all 20 in order, with no drops or duplicates.
- **Reset mid-command:** assert `rst`=0 during WAIT_HI of a write. Expect strobes 0, `fifo_count`=0 and `rd_ready`=1 immediately.
- **Timeout (with macro, TIMEOUT=16):** the controller model never raises `ram_done`. After 16 wait cycles expect `err`=1 and the strobe low; a read completes with `rd_data`=0.
